// File: rtl/ttt_game_ctrl_pkg.sv
// Shared definitions for the tic-tac-toe game path: sprite/winner codes,
// sequencer states, the line table and cell index helpers.
package ttt_game_ctrl_pkg;

  localparam logic [1:0] SPR_EMPTY = 2'b00;
  localparam logic [1:0] SPR_X     = 2'b01;
  localparam logic [1:0] SPR_O     = 2'b10;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_X     = 2'b01;
  localparam logic [1:0] WIN_O     = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  localparam logic [2:0] LAST_LINE = 3'd7;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'b00,
    ST_CHECK   = 2'b01,
    ST_RESOLVE = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  // row*3+col without a multiplier
  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  endfunction

  // three cell indices per line, packed {a,b,c}
  function automatic logic [11:0] line_cells(input logic [2:0] line);
    case (line)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      3'd7:    return {4'd2, 4'd4, 4'd6};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [8:0] line_mask(input logic [2:0] line);
    case (line)
      3'd0:    return 9'h007;
      3'd1:    return 9'h038;
      3'd2:    return 9'h1C0;
      3'd3:    return 9'h049;
      3'd4:    return 9'h092;
      3'd5:    return 9'h124;
      3'd6:    return 9'h111;
      3'd7:    return 9'h054;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [1:0] cell_of(input logic [17:0] cells, input logic [3:0] idx);
    case (idx)
      4'd0:    return cells[1:0];
      4'd1:    return cells[3:2];
      4'd2:    return cells[5:4];
      4'd3:    return cells[7:6];
      4'd4:    return cells[9:8];
      4'd5:    return cells[11:10];
      4'd6:    return cells[13:12];
      4'd7:    return cells[15:14];
      4'd8:    return cells[17:16];
      default: return SPR_EMPTY;
    endcase
  endfunction

  function automatic logic [1:0] toggle_player(input logic [1:0] p);
    return (p == SPR_X) ? SPR_O : SPR_X;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_board.sv
// 9x2-bit board store: one synchronous write port, single-cycle clear,
// a registered {row,col} read port and a flat combinational view.
module ttt_board
  import ttt_game_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        clr,
  input  logic [3:0]  widx,
  input  logic [1:0]  wdata,
  input  logic [3:0]  raddr,
  output logic [1:0]  rdata,
  output logic [17:0] cells
);

  logic [17:0] cells_r;
  logic [1:0]  rdata_r;

  // cell storage; clear wins over write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_r <= 18'h00000;
    end else if (clr) begin
      cells_r <= 18'h00000;
    end else if (we) begin
      for (int i = 0; i < 9; i++) begin
        if (widx == 4'(i)) begin
          cells_r[2*i +: 2] <= wdata;
        end
      end
    end
  end

  // raster read port; row 3 or col 3 is off-board
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= SPR_EMPTY;
    end else if ((raddr[3:2] == 2'b11) || (raddr[1:0] == 2'b11)) begin
      rdata_r <= SPR_EMPTY;
    end else begin
      rdata_r <= cell_of(cells_r, cell_index(raddr[3:2], raddr[1:0]));
    end
  end

  assign rdata = rdata_r;
  assign cells = cells_r;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: cursor, move placement, sequential
// win/draw scan and game-over reporting for the display path.
module ttt_game_ctrl
  import ttt_game_ctrl_pkg::*;
#(
  parameter logic [1:0] START_PLAYER = 2'b01,
  parameter logic [3:0] CURSOR_INIT  = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic [3:0] saddr,
  output logic [3:0] uaddr,
  output logic [1:0] sprite,
  output logic [9:0] gameover,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic       busy
);

  state_t      state_r;
  logic [1:0]  row_r;
  logic [1:0]  col_r;
  logic [1:0]  turn_r;
  logic [1:0]  winner_r;
  logic [9:0]  gameover_r;
  logic        busy_r;
  logic [2:0]  line_r;
  logic [8:0]  win_mask_r;

  logic [17:0] cells_s;
  logic [3:0]  cur_idx_s;
  logic        cur_empty_s;
  logic        we_s;
  logic        clr_s;
  logic [11:0] line_idx_s;
  logic        line_hit_s;
  logic        full_s;

  // cursor cell lookup and board write/clear strobes
  always_comb begin
    cur_idx_s   = cell_index(row_r, col_r);
    cur_empty_s = (cell_of(cells_s, cur_idx_s) == SPR_EMPTY);
    we_s        = (state_r == ST_PLAY) && btn_place && cur_empty_s;
    clr_s       = (state_r == ST_OVER) && btn_place;
  end

  // current scan line match and full-board detection
  always_comb begin
    line_idx_s = line_cells(line_r);
    line_hit_s = (cell_of(cells_s, line_idx_s[11:8]) == turn_r) &&
                 (cell_of(cells_s, line_idx_s[7:4])  == turn_r) &&
                 (cell_of(cells_s, line_idx_s[3:0])  == turn_r);
    full_s = 1'b1;
    for (int i = 0; i < 9; i++) begin
      full_s = full_s & (cells_s[2*i +: 2] != SPR_EMPTY);
    end
  end

  ttt_board u_board (
    .clk   (clk),
    .rst_n (rst),
    .we    (we_s),
    .clr   (clr_s),
    .widx  (cur_idx_s),
    .wdata (turn_r),
    .raddr (saddr),
    .rdata (sprite),
    .cells (cells_s)
  );

  // game sequencer; place outranks every cursor move in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_PLAY;
      row_r      <= CURSOR_INIT[3:2];
      col_r      <= CURSOR_INIT[1:0];
      turn_r     <= START_PLAYER;
      winner_r   <= WIN_NONE;
      gameover_r <= 10'h000;
      busy_r     <= 1'b0;
      line_r     <= 3'd0;
      win_mask_r <= 9'h000;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (btn_place) begin
            if (cur_empty_s) begin
              line_r     <= 3'd0;
              win_mask_r <= 9'h000;
              busy_r     <= 1'b1;
              state_r    <= ST_CHECK;
            end
          end else if (btn_up) begin
            row_r <= (row_r == 2'd0) ? 2'd2 : row_r - 2'd1;
          end else if (btn_down) begin
            row_r <= (row_r == 2'd2) ? 2'd0 : row_r + 2'd1;
          end else if (btn_left) begin
            col_r <= (col_r == 2'd0) ? 2'd2 : col_r - 2'd1;
          end else if (btn_right) begin
            col_r <= (col_r == 2'd2) ? 2'd0 : col_r + 2'd1;
          end
        end
        ST_CHECK: begin
          if (line_hit_s) begin
            win_mask_r <= win_mask_r | line_mask(line_r);
          end
          if (line_r == LAST_LINE) begin
            state_r <= ST_RESOLVE;
          end else begin
            line_r <= line_r + 3'd1;
          end
        end
        ST_RESOLVE: begin
          busy_r <= 1'b0;
          if (win_mask_r != 9'h000) begin
            gameover_r <= {1'b1, win_mask_r};
            winner_r   <= turn_r;
            state_r    <= ST_OVER;
          end else if (full_s) begin
            gameover_r <= {1'b1, 9'h000};
            winner_r   <= WIN_DRAW;
            state_r    <= ST_OVER;
          end else begin
            turn_r  <= toggle_player(turn_r);
            state_r <= ST_PLAY;
          end
        end
        ST_OVER: begin
          if (btn_place) begin
            gameover_r <= 10'h000;
            winner_r   <= WIN_NONE;
            turn_r     <= START_PLAYER;
            state_r    <= ST_PLAY;
          end
        end
        default: begin
          state_r <= ST_PLAY;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign uaddr    = {row_r, col_r};
  assign turn     = turn_r;
  assign winner   = winner_r;
  assign gameover = gameover_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: cursor vector table plus hand-written
// game sequences for win, draw, double win, occupied cell and mid-scan reset.
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_place = 1'b0;
  logic [3:0] saddr = 4'h0;
  logic [3:0] uaddr;
  logic [1:0] sprite;
  logic [9:0] gameover;
  logic [1:0] turn;
  logic [1:0] winner;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cur_row = 1;
  int cur_col = 1;

  localparam logic [4:0] B_PLACE = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  typedef struct packed {
    logic [4:0] btn;
    logic [3:0] exp_uaddr;
  } vec_t;

  vec_t vecs [11];

  ttt_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_place (btn_place),
    .saddr     (saddr),
    .uaddr     (uaddr),
    .sprite    (sprite),
    .gameover  (gameover),
    .turn      (turn),
    .winner    (winner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [4:0] b);
    @(negedge clk);
    {btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk);
    {btn_place, btn_up, btn_down, btn_left, btn_right} = 5'b00000;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_cell(input string name, input logic [3:0] a, input logic [1:0] exp);
    saddr = a;
    @(negedge clk);
    chk(name, 32'(sprite), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    cur_row = 1;
    cur_col = 1;
  endtask

  task automatic goto_cell(input int r, input int c);
    while (cur_row != r) begin
      pulse(B_DOWN);
      cur_row = (cur_row == 2) ? 0 : cur_row + 1;
    end
    while (cur_col != c) begin
      pulse(B_RIGHT);
      cur_col = (cur_col == 2) ? 0 : cur_col + 1;
    end
    chk("goto_uaddr", 32'(uaddr), 32'((cur_row * 4) + cur_col));
  endtask

  // place at address a; check busy window and the outputs at T+10
  task automatic move(input logic [3:0] a, input logic [9:0] exp_go,
                      input logic [1:0] exp_win, input logic [1:0] exp_turn);
    goto_cell(int'(a[3:2]), int'(a[1:0]));
    pulse(B_PLACE);
    chk("busy_check", 32'(busy), 32'd1);
    tick(8);
    chk("busy_resolve", 32'(busy), 32'd1);
    chk("gameover_pending", 32'(gameover), 32'd0);
    tick(1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("move_gameover", 32'(gameover), 32'(exp_go));
    chk("move_winner", 32'(winner), 32'(exp_win));
    chk("move_turn", 32'(turn), 32'(exp_turn));
  endtask

  initial begin
    vecs[0]  = '{btn: B_RIGHT,          exp_uaddr: 4'h6};
    vecs[1]  = '{btn: B_RIGHT,          exp_uaddr: 4'h4};
    vecs[2]  = '{btn: B_RIGHT,          exp_uaddr: 4'h5};
    vecs[3]  = '{btn: B_UP,             exp_uaddr: 4'h1};
    vecs[4]  = '{btn: B_UP,             exp_uaddr: 4'h9};
    vecs[5]  = '{btn: B_UP | B_DOWN,    exp_uaddr: 4'h5};
    vecs[6]  = '{btn: B_DOWN | B_LEFT,  exp_uaddr: 4'h9};
    vecs[7]  = '{btn: B_LEFT | B_RIGHT, exp_uaddr: 4'h8};
    vecs[8]  = '{btn: B_LEFT,           exp_uaddr: 4'hA};
    vecs[9]  = '{btn: B_DOWN,           exp_uaddr: 4'h2};
    vecs[10] = '{btn: B_RIGHT,          exp_uaddr: 4'h0};

    // reset state
    tick(2);
    chk("rst_uaddr", 32'(uaddr), 32'h5);
    chk("rst_sprite", 32'(sprite), 32'h0);
    chk("rst_gameover", 32'(gameover), 32'h0);
    chk("rst_turn", 32'(turn), 32'h1);
    chk("rst_winner", 32'(winner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;

    // cursor wrap and button priority
    for (int i = 0; i < 11; i++) begin
      pulse(vecs[i].btn);
      chk($sformatf("vec%0d_uaddr", i), 32'(uaddr), 32'(vecs[i].exp_uaddr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end
    cur_row = int'(vecs[10].exp_uaddr[3:2]);
    cur_col = int'(vecs[10].exp_uaddr[1:0]);

    // X wins row 0
    move(4'h0, 10'h000, 2'b00, 2'b10);
    move(4'h4, 10'h000, 2'b00, 2'b01);
    move(4'h1, 10'h000, 2'b00, 2'b10);
    move(4'h5, 10'h000, 2'b00, 2'b01);
    move(4'h2, 10'h207, 2'b01, 2'b01);
    read_cell("spr_x_at_1", 4'h1, 2'b01);
    read_cell("spr_o_at_4", 4'h4, 2'b10);
    read_cell("spr_off_f", 4'hF, 2'b00);
    read_cell("spr_off_3", 4'h3, 2'b00);
    read_cell("spr_off_c", 4'hC, 2'b00);

    // cursor frozen in OVER, then place starts a new game
    pulse(B_RIGHT);
    chk("over_frozen", 32'(uaddr), 32'h2);
    pulse(B_PLACE);
    chk("clr_gameover", 32'(gameover), 32'h0);
    chk("clr_winner", 32'(winner), 32'h0);
    chk("clr_turn", 32'(turn), 32'h1);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_uaddr", 32'(uaddr), 32'h2);
    read_cell("clr_cell0", 4'h0, 2'b00);
    read_cell("clr_cell2", 4'h2, 2'b00);

    // occupied cell is ignored
    move(4'h2, 10'h000, 2'b00, 2'b10);
    pulse(B_PLACE);
    chk("occ_busy", 32'(busy), 32'd0);
    tick(10);
    chk("occ_turn", 32'(turn), 32'h2);
    chk("occ_gameover", 32'(gameover), 32'h0);
    read_cell("occ_cell", 4'h2, 2'b01);

    // draw
    do_reset();
    move(4'h0, 10'h000, 2'b00, 2'b10);
    move(4'h1, 10'h000, 2'b00, 2'b01);
    move(4'h2, 10'h000, 2'b00, 2'b10);
    move(4'h4, 10'h000, 2'b00, 2'b01);
    move(4'h5, 10'h000, 2'b00, 2'b10);
    move(4'h8, 10'h000, 2'b00, 2'b01);
    move(4'h6, 10'h000, 2'b00, 2'b10);
    move(4'hA, 10'h000, 2'b00, 2'b01);
    move(4'h9, 10'h200, 2'b11, 2'b01);

    // double win: row 1 and col 1
    do_reset();
    move(4'h1, 10'h000, 2'b00, 2'b10);
    move(4'h0, 10'h000, 2'b00, 2'b01);
    move(4'h4, 10'h000, 2'b00, 2'b10);
    move(4'h2, 10'h000, 2'b00, 2'b01);
    move(4'h6, 10'h000, 2'b00, 2'b10);
    move(4'h8, 10'h000, 2'b00, 2'b01);
    move(4'h9, 10'h000, 2'b00, 2'b10);
    move(4'hA, 10'h000, 2'b00, 2'b01);
    move(4'h5, 10'h2BA, 2'b01, 2'b01);

    // reset asserted during CHECK cycle 4
    do_reset();
    saddr = 4'h5;
    pulse(B_PLACE);
    chk("mid_busy", 32'(busy), 32'd1);
    tick(3);
    chk("mid_sprite_before", 32'(sprite), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_uaddr", 32'(uaddr), 32'h5);
    chk("mid_rst_sprite", 32'(sprite), 32'h0);
    chk("mid_rst_gameover", 32'(gameover), 32'h0);
    chk("mid_rst_turn", 32'(turn), 32'h1);
    chk("mid_rst_winner", 32'(winner), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(8);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_turn", 32'(turn), 32'h1);
    chk("post_rst_gameover", 32'(gameover), 32'h0);
    read_cell("post_rst_cell5", 4'h5, 2'b00);
    read_cell("post_rst_f", 4'hF, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
